// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin N-master to 1-slave Wishbone B3 arbiter with per-access watchdog
module wb_rr_arbiter #(
   parameter int NM      = 4,
   parameter int DW      = 32,
   parameter int AW      = 32,
   parameter int TIMEOUT = 256
)(
   input  logic            wb_clk_i,
   input  logic            wb_rst_ni,
   input  logic [NM*AW-1:0] wbm_adr_i,
   input  logic [NM*DW-1:0] wbm_dat_i,
   input  logic [NM*4-1:0]  wbm_sel_i,
   input  logic [NM*3-1:0]  wbm_cti_i,
   input  logic [NM*2-1:0]  wbm_bte_i,
   input  logic [NM-1:0]    wbm_we_i,
   input  logic [NM-1:0]    wbm_cyc_i,
   input  logic [NM-1:0]    wbm_stb_i,
   output logic [DW-1:0]    wbm_dat_o,
   output logic [NM-1:0]    wbm_ack_o,
   output logic [NM-1:0]    wbm_err_o,
   output logic [NM-1:0]    wbm_rty_o,
   output logic [AW-1:0]    wbs_adr_o,
   output logic [DW-1:0]    wbs_dat_o,
   output logic [3:0]       wbs_sel_o,
   output logic [2:0]       wbs_cti_o,
   output logic [1:0]       wbs_bte_o,
   output logic             wbs_we_o,
   output logic             wbs_cyc_o,
   output logic             wbs_stb_o,
   input  logic [DW-1:0]    wbs_dat_i,
   input  logic             wbs_ack_i,
   input  logic             wbs_err_i,
   output logic [NM-1:0]    grant_o
);
   localparam int LW = NM > 1 ? $clog2(NM) : 1;
   localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
   typedef enum logic {IDLE, GRANT} state_e;
   state_e        state_q, state_d;
   logic [NM-1:0] grant_q, grant_d;
   logic [LW-1:0] last_q, last_d, gidx;
   logic [WW-1:0] wdog_q, wdog_d;
   logic          gcyc, gstb, to_err, found;
   always_comb begin
      wbs_adr_o = '0;
      wbs_dat_o = '0;
      wbs_sel_o = '0;
      wbs_cti_o = '0;
      wbs_bte_o = '0;
      wbs_we_o  = 1'b0;
      gcyc      = 1'b0;
      gstb      = 1'b0;
      gidx      = '0;
      for (int i = 0; i < NM; i++)
         if (grant_q[i]) begin
            wbs_adr_o = wbm_adr_i[i*AW +: AW];
            wbs_dat_o = wbm_dat_i[i*DW +: DW];
            wbs_sel_o = wbm_sel_i[i*4 +: 4];
            wbs_cti_o = wbm_cti_i[i*3 +: 3];
            wbs_bte_o = wbm_bte_i[i*2 +: 2];
            wbs_we_o  = wbm_we_i[i];
            gcyc      = wbm_cyc_i[i];
            gstb      = wbm_stb_i[i];
            gidx      = LW'(i);
         end
   end
   assign wbs_cyc_o = gcyc;
   assign wbs_stb_o = gstb & ~to_err;
   // An ACK or ERR arriving in the timeout cycle takes precedence over the forced ERR
   assign to_err = (TIMEOUT > 0) && gstb && !wbs_ack_i && !wbs_err_i && wdog_q == WW'(TIMEOUT - 1);
   assign wdog_d = (TIMEOUT == 0 || !gstb || wbs_ack_i || wbs_err_i || to_err) ? '0 :
                   (&wdog_q) ? wdog_q : wdog_q + 1'b1;
   assign wbm_dat_o = wbs_dat_i;
   assign wbm_ack_o = {NM{wbs_ack_i}} & grant_q;
   assign wbm_err_o = {NM{wbs_err_i | to_err}} & grant_q;
   assign wbm_rty_o = '0;
   assign grant_o   = grant_q;
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      found   = 1'b0;
      if (state_q == IDLE) begin
         // Two passes give the circular scan starting just after the last owner
         for (int i = 0; i < NM; i++)
            if (!found && wbm_cyc_i[i] && i > int'(last_q)) begin
               grant_d[i] = 1'b1;
               found      = 1'b1;
            end
         for (int i = 0; i < NM; i++)
            if (!found && wbm_cyc_i[i] && i <= int'(last_q)) begin
               grant_d[i] = 1'b1;
               found      = 1'b1;
            end
         state_d = found ? GRANT : IDLE;
      end else if (!gcyc) begin
         grant_d = '0;
         last_d  = gidx;
         state_d = IDLE;
      end
   end
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
      if (!wb_rst_ni) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= LW'(NM - 1);
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         wdog_q  <= wdog_d;
      end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed checks of grant order, burst hold, watchdog and async reset
module tb_wb_rr_arbiter;
   localparam int NM = 4, DW = 32, AW = 32;
   logic clk = 1'b0, rst_n = 1'b1;
   logic [NM*AW-1:0] adr;
   logic [NM*DW-1:0] dat;
   logic [NM*4-1:0]  sel;
   logic [NM*3-1:0]  cti;
   logic [NM*2-1:0]  bte;
   logic [NM-1:0]    we, cyc, stb;
   logic [DW-1:0]    mdat, sdat_o, sdat_i;
   logic [NM-1:0]    ack_o, err_o, rty_o, grant;
   logic [AW-1:0]    sadr;
   logic [3:0]       ssel;
   logic [2:0]       scti;
   logic [1:0]       sbte;
   logic             swe, scyc, sstb, sack, serr;
   int n_cmp = 0, n_err = 0;

   wb_rr_arbiter #(.NM(NM), .DW(DW), .AW(AW), .TIMEOUT(16)) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .wbm_adr_i(adr), .wbm_dat_i(dat), .wbm_sel_i(sel), .wbm_cti_i(cti), .wbm_bte_i(bte),
      .wbm_we_i(we), .wbm_cyc_i(cyc), .wbm_stb_i(stb),
      .wbm_dat_o(mdat), .wbm_ack_o(ack_o), .wbm_err_o(err_o), .wbm_rty_o(rty_o),
      .wbs_adr_o(sadr), .wbs_dat_o(sdat_o), .wbs_sel_o(ssel), .wbs_cti_o(scti), .wbs_bte_o(sbte),
      .wbs_we_o(swe), .wbs_cyc_o(scyc), .wbs_stb_o(sstb),
      .wbs_dat_i(sdat_i), .wbs_ack_i(sack), .wbs_err_i(serr), .grant_o(grant)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < NM; i++) begin
         adr[i*AW +: AW] = 32'h1000 * (i + 1);
         dat[i*DW +: DW] = 32'hD000 + i;
      end
      sel = '1; cti = '0; bte = '0; we = 4'b0010; cyc = '0; stb = '0;
      sdat_i = 32'hCAFEF00D; sack = 1'b0; serr = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_grant", grant, 0);
      chk("rst_scyc", scyc, 0);
      chk("rst_ack", ack_o, 0);
      chk("rst_err", err_o, 0);
      tick(); tick();
      rst_n = 1'b1;
      // Test 1: m0 and m2 together
      cyc = 4'b0101; stb = 4'b0101;
      tick();
      chk("t1_grant_m0", grant, 4'b0001);
      chk("t1_sadr_m0", sadr, 32'h1000);
      chk("t1_scyc", scyc, 1);
      chk("t1_mdat", mdat, 32'hCAFEF00D);
      cyc[0] = 1'b0; stb[0] = 1'b0;
      tick();
      chk("t1_dead", grant, 4'b0000);
      tick();
      chk("t1_grant_m2", grant, 4'b0100);
      chk("t1_sadr_m2", sadr, 32'h3000);
      cyc = '0; stb = '0;
      tick(); tick();
      // Test 2: all masters back-to-back, fresh priority
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      cyc = 4'b1111; stb = 4'b1111;
      for (int r = 0; r < 6; r++) begin
         tick();
         chk($sformatf("t2_grant_r%0d", r), grant, 1 << (r % 4));
         sack = 1'b1;
         #1;
         chk($sformatf("t2_ack_r%0d", r), ack_o, 1 << (r % 4));
         tick();
         sack = 1'b0; cyc[r % 4] = 1'b0; stb[r % 4] = 1'b0;
         tick();
         chk($sformatf("t2_dead_r%0d", r), grant, 0);
         cyc[r % 4] = 1'b1; stb[r % 4] = 1'b1;
      end
      cyc = '0; stb = '0;
      tick();
      chk("t2_idle", grant, 0);
      // Test 3: 8-beat burst by m1 while m0 and m3 request
      cti[5:3] = 3'b010; cyc[1] = 1'b1; stb[1] = 1'b1;
      tick();
      chk("t3_grant_m1", grant, 4'b0010);
      chk("t3_cti", scti, 3'b010);
      chk("t3_we", swe, 1);
      cyc[0] = 1'b1; cyc[3] = 1'b1; stb[0] = 1'b1; stb[3] = 1'b1;
      sack = 1'b1;
      for (int b = 0; b < 8; b++) begin
         #1;
         chk($sformatf("t3_ack_b%0d", b), ack_o, 4'b0010);
         chk($sformatf("t3_hold_b%0d", b), grant, 4'b0010);
         tick();
      end
      sack = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0; cti = '0;
      #1;
      chk("t3_hold_end", grant, 4'b0010);
      tick();
      chk("t3_dead", grant, 0);
      tick();
      chk("t3_next_m3", grant, 4'b1000);
      cyc = '0; stb = '0;
      tick(); tick();
      // Test 4: slave never answers m2
      cyc[2] = 1'b1; stb[2] = 1'b1;
      for (int k = 1; k < 16; k++) begin
         tick();
         if (k == 1) begin
            chk("t4_grant_m2", grant, 4'b0100);
            cyc[0] = 1'b1; stb[0] = 1'b1;
         end
         chk($sformatf("t4_noerr_k%0d", k), err_o, 0);
      end
      tick();
      chk("t4_err_m2", err_o, 4'b0100);
      chk("t4_noack", ack_o, 0);
      chk("t4_stb_masked", sstb, 0);
      tick();
      chk("t4_err_one_cycle", err_o, 0);
      cyc[2] = 1'b0; stb[2] = 1'b0;
      tick();
      chk("t4_dead", grant, 0);
      tick();
      chk("t4_grant_m0", grant, 4'b0001);
      sack = 1'b1;
      #1;
      chk("t4_ack_m0", ack_o, 4'b0001);
      chk("t4_noerr_m0", err_o, 0);
      tick();
      sack = 1'b0; cyc = '0; stb = '0;
      tick(); tick();
      // Test 5: ACK exactly on the timeout cycle
      cyc[1] = 1'b1; stb[1] = 1'b1;
      for (int k = 1; k < 16; k++) tick();
      chk("t5_noerr_k15", err_o, 0);
      tick();
      sack = 1'b1;
      #1;
      chk("t5_ack", ack_o, 4'b0010);
      chk("t5_noerr", err_o, 0);
      chk("t5_stb", sstb, 1);
      tick();
      sack = 1'b0; cyc = '0; stb = '0;
      tick(); tick();
      // Test 6: async reset mid-burst by m3
      cyc[3] = 1'b1; stb[3] = 1'b1;
      tick();
      chk("t6_grant_m3", grant, 4'b1000);
      sack = 1'b1;
      tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_grant", grant, 0);
      chk("t6_rst_scyc", scyc, 0);
      chk("t6_rst_ack", ack_o, 0);
      sack = 1'b0; cyc = 4'b1001; stb = 4'b1001;
      tick();
      rst_n = 1'b1;
      tick();
      chk("t6_grant_m0", grant, 4'b0001);
      chk("rty_zero", rty_o, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
